fwd_hazard_tracker: RTL and testbench
=====================================

Name: fwd_hazard_tracker

Overview:
- Parametrised forwarding and hazard unit for the pipelined ARM core.
- Keeps its own shadow pipeline of in-flight writer tuples (dest, wb_en, is_load) for DEPTH stages past ID. The datapath no longer has to route per-stage dest and wb_en signals to this unit.
- Produces one forwarding select per source operand, a load-use / no-forward stall, and a saturating stall-cycle counter for performance statistics.
- Sits beside the ID stage: inputs come from the decoder; outputs drive the EX operand muxes and the IF/ID freeze.

Parameters:
- NSRC, 2: number of source operands checked per instruction.
- AW, 4: register address width.
- DEPTH, 3: tracked stages after ID. Stage 1 = EX, 2 = MEM, DEPTH = WB.
- LOAD_STAGE, 2: first stage at which a load result can be forwarded.
- SELW, 2: select width; must satisfy 2^SELW > DEPTH.
- CNTW, 16: stall counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active high
- id_valid  in  1  ID holds a real instruction
- id_src  in  NSRC*AW  source register numbers; operand i is at [i*AW +: AW]
- id_src_used  in  NSRC  operand i is actually read
- id_dest  in  AW  destination register of the ID instruction
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- forward_en  in  1  forwarding mode enable
- flush  in  1  branch taken; kill the ID instruction
- sel  out  NSRC*SELW  per-operand select: 0 = register file, k = stage k result
- stall  out  1  freeze PC and IF/ID, inject bubble
- stall_cycles  out  CNTW  saturating count of stalled cycles

Behaviour:
- Reset is asynchronous and active high, on clk and rst:
  - all tracker entries invalid (wb_en=0, is_load=0, dest=0)
  - stall_cycles=0
  - as a consequence, stall=0 and every sel=0 while rst is high and in the first cycle after release
- Tracker, updated every rising edge:
  - entries 2..DEPTH always shift from k-1 to k; stall never freezes stages past ID
  - entry 1 loads {id_dest, id_wb_en & id_valid, id_mem_read & id_valid} when !stall && !flush
  - otherwise entry 1 loads a bubble (wb_en=0)
  - entry DEPTH drops out on the next shift
- Match definition: operand i matches stage k when id_valid, id_src_used[i], entry k wb_en, and entry k dest == id_src[i].
- forward_en=1:
  - sel[i] = smallest (youngest) matching k in 1..DEPTH; 0 if there is no match
  - stall when any operand matches a stage k < LOAD_STAGE whose is_load=1, and that stage is the youngest match for that operand
- forward_en=0:
  - sel all 0
  - stall when any operand matches any stage k in 1..DEPTH-1
  - stage DEPTH is covered by register-file write-through and never stalls
- While stall=1, all sel=0. The ID instruction is re-evaluated each cycle until the hazard clears.
- flush=1 forces stall=0 that cycle (the killed instruction cannot hazard) and inserts a bubble into entry 1.
- stall and sel are combinational from tracker state and ID inputs; there is no added latency.
- stall_cycles increments on every edge where stall=1 and saturates at all ones.
- forward_en toggling mid-stream takes effect in the same cycle; tracker contents are unaffected.
- Reset asserted mid-operation clears the tracker immediately; any pending stall deasserts asynchronously.

Decomposition:
- Shared package/include holds the select encodings: SEL_RF=0, and stage k encodes as k.
- It also holds the default constants for DEPTH and LOAD_STAGE, reused by the datapath operand muxes.
- One natural sub-module, fwd_src_match: the per-operand combinational priority match over DEPTH entries, producing sel and need_stall for that operand. It is instantiated NSRC times via generate.

Test Plan (NSRC=2, AW=4, DEPTH=3, LOAD_STAGE=2):
- ADD R1 issued, next cycle SUB src0=R1, forward_en=1 -> sel[0]=1, stall=0; one cycle later with an unrelated instruction in between, src0=R1 -> sel[0]=2.
- LDR R2 then ADD src1=R2 immediately, forward_en=1 -> stall=1 for exactly 1 cycle, stall_cycles=1, then sel[1]=2.
- forward_en=0, ADD R3 then SUB src0=R3 -> stall=1 for 2 cycles, sel=0 throughout, then proceed with sel=0.
- Stages 1 and 2 both write R4, ID reads R4 on both operands -> sel[0]=sel[1]=1 (youngest wins). id_src_used[1]=0 -> sel[1]=0.
- Load-use pending with flush=1 in the same cycle -> stall=0, entry 1 bubble; the following instruction reading R2 sees no stage-1 match.
- rst pulsed mid load-use stall -> stall and sel drop to 0 asynchronously, stall_cycles=0. Separately, force 2^CNTW+5 stall cycles -> stall_cycles holds 0xFFFF.

Source files
------------

// File: rtl/fwd_hazard_tracker_pkg.sv
// Shared select encodings and default pipeline geometry for
// the forwarding/hazard tracker and the EX operand muxes.
package fwd_hazard_tracker_pkg;

  localparam int DEF_DEPTH      = 3;
  localparam int DEF_LOAD_STAGE = 2;
  localparam int SEL_RF         = 0;

  // Stage k result is selected with code k.
  function automatic int sel_stage(input int k);
    return k;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Per-operand priority match of one source register against
// the in-flight writer entries; youngest stage wins.
module fwd_src_match
  import fwd_hazard_tracker_pkg::*;
#(
  parameter int AW         = 4,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LOAD_STAGE = DEF_LOAD_STAGE,
  parameter int SELW       = 2
) (
  input  logic                      i_rd,
  input  logic [AW-1:0]             i_src,
  input  logic [DEPTH-1:0][AW-1:0]  i_dest,
  input  logic [DEPTH-1:0]          i_wb_en,
  input  logic [DEPTH-1:0]          i_is_load,
  input  logic                      i_fwd_en,
  output logic [SELW-1:0]           o_sel,
  output logic                      o_need_stall
);

  logic [DEPTH-1:0] w_hit;
  logic [SELW-1:0]  w_young;
  logic             w_young_ld;
  logic             w_nofwd;

  always_comb begin
    w_hit = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_hit[k] = i_rd & i_wb_en[k]
               & (i_dest[k] == i_src);
    end
  end

  always_comb begin
    w_young    = SELW'(SEL_RF);
    w_young_ld = 1'b0;
    w_nofwd    = 1'b0;
    // Walk oldest to youngest so the youngest hit is left.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_young    = SELW'(sel_stage(k + 1));
        w_young_ld = i_is_load[k]
                   && ((k + 1) < LOAD_STAGE);
      end
    end
    for (int k = 0; k < DEPTH - 1; k++) begin
      w_nofwd = w_nofwd | w_hit[k];
    end
    o_sel        = i_fwd_en ? w_young
                            : SELW'(SEL_RF);
    o_need_stall = i_fwd_en ? w_young_ld : w_nofwd;
  end

endmodule

// File: rtl/fwd_hazard_tracker.sv
// Forwarding and hazard unit beside ID: shadow writer pipeline,
// per-operand forwarding selects, stall and stall counter.
module fwd_hazard_tracker
  import fwd_hazard_tracker_pkg::*;
#(
  parameter int NSRC       = 2,
  parameter int AW         = 4,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LOAD_STAGE = DEF_LOAD_STAGE,
  parameter int SELW       = 2,
  parameter int CNTW       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_src,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic [AW-1:0]        id_dest,
  input  logic                 id_wb_en,
  input  logic                 id_mem_read,
  input  logic                 forward_en,
  input  logic                 flush,
  output logic [NSRC*SELW-1:0] sel,
  output logic                 stall,
  output logic [CNTW-1:0]      stall_cycles
);

  logic [DEPTH-1:0][AW-1:0] r_dest;
  logic [DEPTH-1:0]         r_wb;
  logic [DEPTH-1:0]         r_ld;
  logic [CNTW-1:0]          r_cnt;

  logic [NSRC-1:0]          w_need;
  logic [NSRC*SELW-1:0]     w_sel;
  logic                     w_stall;
  logic                     w_issue;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    fwd_src_match #(
      .AW         (AW),
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE),
      .SELW       (SELW)
    ) u_match (
      .i_rd         (id_valid & id_src_used[g]),
      .i_src        (id_src[g*AW +: AW]),
      .i_dest       (r_dest),
      .i_wb_en      (r_wb),
      .i_is_load    (r_ld),
      .i_fwd_en     (forward_en),
      .o_sel        (w_sel[g*SELW +: SELW]),
      .o_need_stall (w_need[g])
    );
  end

  // A flushed instruction is dead, so it can never hazard.
  assign w_stall = (|w_need) & ~flush;
  assign w_issue = ~w_stall & ~flush;

  assign stall        = w_stall;
  assign sel          = w_stall ? '0 : w_sel;
  assign stall_cycles = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dest <= '0;
      r_wb   <= '0;
      r_ld   <= '0;
      r_cnt  <= '0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        r_dest[k] <= r_dest[k-1];
        r_wb[k]   <= r_wb[k-1];
        r_ld[k]   <= r_ld[k-1];
      end
      if (w_issue) begin
        r_dest[0] <= id_dest;
        r_wb[0]   <= id_wb_en & id_valid;
        r_ld[0]   <= id_mem_read & id_valid;
      end else begin
        r_dest[0] <= '0;
        r_wb[0]   <= 1'b0;
        r_ld[0]   <= 1'b0;
      end
      if (w_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Table-driven scoreboard bench for fwd_hazard_tracker with
// hand sequences for async reset and counter saturation.
module tb_fwd_hazard_tracker;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [7:0]  id_src;
  logic [1:0]  id_src_used;
  logic [3:0]  id_dest;
  logic        id_wb_en;
  logic        id_mem_read;
  logic        forward_en;
  logic        flush;
  logic [3:0]  sel;
  logic        stall;
  logic [15:0] stall_cycles;
  logic [3:0]  sel_s;
  logic        stall_s;
  logic [3:0]  cnt_s;

  fwd_hazard_tracker u_dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_mem_read  (id_mem_read),
    .forward_en   (forward_en),
    .flush        (flush),
    .sel          (sel),
    .stall        (stall),
    .stall_cycles (stall_cycles)
  );

  fwd_hazard_tracker #(.CNTW(4)) u_small (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_mem_read  (id_mem_read),
    .forward_en   (forward_en),
    .flush        (flush),
    .sel          (sel_s),
    .stall        (stall_s),
    .stall_cycles (cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        v;
    logic [3:0]  s0;
    logic [3:0]  s1;
    logic [1:0]  u;
    logic [3:0]  d;
    logic        w;
    logic        l;
    logic        f;
    logic        fl;
    logic        es;
    logic [1:0]  e0;
    logic [1:0]  e1;
    logic [15:0] ec;
  } vec_t;

  typedef struct {
    logic        st;
    logic [3:0]  sl;
    logic [15:0] cn;
  } exp_t;

  vec_t tbl[24];
  exp_t sb[$];
  int   n_vec;
  int   n_err;

  function automatic vec_t mk(
    input int r, input int v, input int s0,
    input int s1, input int u, input int d,
    input int w, input int l, input int f,
    input int fl, input int es, input int e0,
    input int e1, input int ec);
    vec_t t;
    t.r  = 1'(r);
    t.v  = 1'(v);
    t.s0 = 4'(s0);
    t.s1 = 4'(s1);
    t.u  = 2'(u);
    t.d  = 4'(d);
    t.w  = 1'(w);
    t.l  = 1'(l);
    t.f  = 1'(f);
    t.fl = 1'(fl);
    t.es = 1'(es);
    t.e0 = 2'(e0);
    t.e1 = 2'(e1);
    t.ec = 16'(ec);
    return t;
  endfunction

  task automatic chk(input string nm,
                     input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d",
               nm, act, req);
    end
  endtask

  task automatic drive(input vec_t t);
    rst         = t.r;
    id_valid    = t.v;
    id_src      = {t.s1, t.s0};
    id_src_used = t.u;
    id_dest     = t.d;
    id_wb_en    = t.w;
    id_mem_read = t.l;
    forward_en  = t.f;
    flush       = t.fl;
  endtask

  task automatic apply(input vec_t t, input string nm);
    exp_t e;
    exp_t x;
    int   cs;
    @(posedge clk);
    #1;
    drive(t);
    e.st = t.es;
    e.sl = {t.e1, t.e0};
    e.cn = t.ec;
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    cs = (x.cn > 16'd15) ? 15 : int'(x.cn);
    chk({nm, " stall"}, int'(stall), int'(x.st));
    chk({nm, " sel"}, int'(sel), int'(x.sl));
    chk({nm, " cnt"}, int'(stall_cycles), int'(x.cn));
    chk({nm, " stall4"}, int'(stall_s), int'(x.st));
    chk({nm, " sel4"}, int'(sel_s), int'(x.sl));
    chk({nm, " cnt4"}, int'(cnt_s), cs);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    drive(mk(1,0,0,0,0,0,0,0,1,0,0,0,0,0));

    tbl[0]  = mk(1,1,0,0,3,0,1,0,1,0, 0,0,0,0);
    tbl[1]  = mk(1,1,0,0,3,0,1,0,1,0, 0,0,0,0);
    tbl[2]  = mk(0,1,0,0,0,1,1,0,1,0, 0,0,0,0);
    tbl[3]  = mk(0,1,1,0,1,6,1,0,1,0, 0,1,0,0);
    tbl[4]  = mk(0,1,1,0,1,9,1,0,1,0, 0,2,0,0);
    tbl[5]  = mk(0,1,0,1,2,0,0,0,1,0, 0,0,3,0);
    tbl[6]  = mk(0,1,0,0,0,2,1,1,1,0, 0,0,0,0);
    tbl[7]  = mk(0,1,0,2,2,10,1,0,1,0, 1,0,0,0);
    tbl[8]  = mk(0,1,0,2,2,10,1,0,1,0, 0,0,2,1);
    tbl[9]  = mk(0,0,0,0,0,0,0,0,1,0, 0,0,0,1);
    tbl[10] = mk(0,1,0,0,0,3,1,0,0,0, 0,0,0,1);
    tbl[11] = mk(0,1,3,0,1,11,1,0,0,0, 1,0,0,1);
    tbl[12] = mk(0,1,3,0,1,11,1,0,0,0, 1,0,0,2);
    tbl[13] = mk(0,1,3,0,1,11,1,0,0,0, 0,0,0,3);
    tbl[14] = mk(0,1,11,0,1,0,0,0,1,0, 0,1,0,3);
    tbl[15] = mk(0,1,0,0,0,4,1,0,1,0, 0,0,0,3);
    tbl[16] = mk(0,1,0,0,0,4,1,0,1,0, 0,0,0,3);
    tbl[17] = mk(0,1,4,4,3,0,0,0,1,0, 0,1,1,3);
    tbl[18] = mk(0,1,4,4,1,4,1,0,1,0, 0,2,0,3);
    tbl[19] = mk(0,1,4,4,2,0,0,0,1,0, 0,0,1,3);
    tbl[20] = mk(0,0,4,0,1,0,0,0,1,0, 0,0,0,3);
    tbl[21] = mk(0,1,0,0,0,2,1,1,1,0, 0,0,0,3);
    tbl[22] = mk(0,1,2,0,1,12,1,0,1,1, 0,1,0,3);
    tbl[23] = mk(0,1,2,12,3,0,0,0,1,0, 0,2,0,3);

    for (int i = 0; i < 24; i++) begin
      apply(tbl[i], $sformatf("v%0d", i));
    end

    // Load-use stall interrupted by an asynchronous reset.
    apply(mk(0,1,0,0,0,2,1,1,1,0,0,0,0,3), "ldr");
    @(posedge clk);
    #1;
    drive(mk(0,1,2,0,1,13,1,0,1,0,0,0,0,0));
    #1;
    chk("pre-rst stall", int'(stall), 1);
    chk("pre-rst sel", int'(sel), 0);
    chk("pre-rst cnt", int'(stall_cycles), 3);
    #1;
    rst = 1'b1;
    #1;
    chk("async stall", int'(stall), 0);
    chk("async sel", int'(sel), 0);
    chk("async cnt", int'(stall_cycles), 0);
    chk("async cnt4", int'(cnt_s), 0);
    apply(mk(0,1,2,0,1,13,1,0,1,0,0,0,0,0), "post-rst");

    // Self-dependent writer with forwarding off: 2 of 3 stall.
    for (int i = 0; i < 36; i++) begin
      @(posedge clk);
      #1;
      drive(mk(0,1,5,0,1,5,1,0,0,0,0,0,0,0));
    end
    @(posedge clk);
    #1;
    chk("sat cnt16", int'(stall_cycles), 24);
    chk("sat cnt4", int'(cnt_s), 15);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
